// File: rtl/sng_array.sv
//------------------------------------------------------------------------------
// Module      : sng_array
// Description : Multi-channel stochastic number generator. It turns CHANNELS
//               unsigned operands into unipolar bit streams of length
//               2^WIDTH, with optional per-channel phase offsets.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sng_array #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DECOR    = 1,
    parameter int STRIDE   = 5
) (
    input  logic                      i_clk_sng,
    input  logic                      i_rst_sng,
    input  logic [CHANNELS*WIDTH-1:0] i_x_bn,
    input  logic                      i_start_sng,
    input  logic                      i_stop_sng,
    output logic [CHANNELS-1:0]       o_sn_bits,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GEN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]                r_state;
    logic [WIDTH-1:0]          r_k;
    logic [CHANNELS*WIDTH-1:0] r_x;
    logic [CHANNELS-1:0]       r_sn;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_done;
    logic [CHANNELS-1:0]       w_bits;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [WIDTH-1:0] c_OFFSET =
            (DECOR != 0) ? WIDTH'((c * STRIDE) % (2 ** WIDTH)) : '0;

        logic [WIDTH-1:0] w_p;
        logic [WIDTH:0]   w_q;
        logic [WIDTH-1:0] w_x;
        logic             w_bit;

        assign w_x = r_x[c*WIDTH +: WIDTH];

        // Lowest set bit of p+1 picks the operand bit; p = L-1 leaves it 0.
        always_comb begin
            w_p   = r_k + c_OFFSET;
            w_q   = {1'b0, w_p} + (WIDTH+1)'(1);
            w_bit = 1'b0;
            for (int j = WIDTH - 1; j >= 0; j--) begin
                if (w_q[j]) w_bit = w_x[WIDTH-1-j];
            end
        end

        assign w_bits[c] = w_bit;
    end

    always_ff @(posedge i_clk_sng) begin
        if (i_rst_sng) begin
            r_state <= c_IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_sn    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_sn    <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (i_start_sng) begin
                        r_x     <= i_x_bn;
                        r_k     <= '0;
                        r_state <= c_GEN;
                    end
                end
                c_GEN: begin
                    // Abort takes priority over the final stream cycle.
                    if (i_stop_sng) begin
                        r_sn    <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_k     <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_sn    <= w_bits;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_k     <= r_k + WIDTH'(1);
                        if (r_k == '1) r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_sn    <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_sn    <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign o_sn_bits = r_sn;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sng_array.sv
//------------------------------------------------------------------------------
// Module      : tb_sng_array
// Description : Directed self-checking bench for sng_array (correlated and
//               decorrelated instances).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sng_array;

    logic        clk;
    logic        rst;
    logic [15:0] x0, x1;
    logic        start0, start1, stop0, stop1;
    logic [3:0]  sn0, sn1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    int n_checks;
    int n_pass;
    logic [15:0] seq [4];
    int          vcnt;

    sng_array #(.WIDTH(4), .CHANNELS(4), .DECOR(0), .STRIDE(5)) dut0 (
        .i_clk_sng  (clk),
        .i_rst_sng  (rst),
        .i_x_bn     (x0),
        .i_start_sng(start0),
        .i_stop_sng (stop0),
        .o_sn_bits  (sn0),
        .o_valid    (valid0),
        .o_busy     (busy0),
        .o_done     (done0)
    );

    sng_array #(.WIDTH(4), .CHANNELS(4), .DECOR(1), .STRIDE(5)) dut1 (
        .i_clk_sng  (clk),
        .i_rst_sng  (rst),
        .i_x_bn     (x1),
        .i_start_sng(start1),
        .i_stop_sng (stop1),
        .o_sn_bits  (sn1),
        .o_valid    (valid1),
        .o_busy     (busy1),
        .o_done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({sn0, valid0, busy0, done0, sn1, valid1, busy1, done1} !== 14'd0)
            $display("FAIL reset_outputs got %b want 0",
                     {sn0, valid0, busy0, done0, sn1, valid1, busy1, done1});
        else n_pass++;
        rst = 1'b0;
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        n_checks++;
        if ({sn0, valid0, busy0, done0} !== 7'd0)
            $display("FAIL idle_after_reset got %b want 0", {sn0, valid0, busy0, done0});
        else n_pass++;
    endtask

    task automatic test_correlated;
        x0 = {4'd15, 4'd8, 4'd0, 4'd11};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_checks++;
        if (valid0 !== 1'b0) $display("FAIL corr_valid_at_start got %b want 0", valid0);
        else n_pass++;
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            for (int c = 0; c < 4; c++) seq[c][i] = sn0[c];
            if (valid0 === 1'b1 && busy0 === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 16) $display("FAIL corr_valid_len got %0d want 16", vcnt);
        else n_pass++;
        n_checks++;
        if (seq[3] !== 16'h7FFF) $display("FAIL corr_ch3 got %h want 7fff", seq[3]);
        else n_pass++;
        n_checks++;
        if (seq[2] !== 16'h5555) $display("FAIL corr_ch2 got %h want 5555", seq[2]);
        else n_pass++;
        n_checks++;
        if (seq[1] !== 16'h0000) $display("FAIL corr_ch1 got %h want 0000", seq[1]);
        else n_pass++;
        n_checks++;
        if (seq[0] !== 16'h5DDD) $display("FAIL corr_ch0 got %h want 5ddd", seq[0]);
        else n_pass++;
        tick();
        n_checks++;
        if ({done0, valid0, busy0, sn0} !== 7'b1000000)
            $display("FAIL corr_done_pulse got %b want 1000000", {done0, valid0, busy0, sn0});
        else n_pass++;
        tick();
        n_checks++;
        if (done0 !== 1'b0) $display("FAIL corr_done_width got %b want 0", done0);
        else n_pass++;
    endtask

    task automatic test_decor;
        x1 = {4{4'd8}};
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            for (int c = 0; c < 4; c++) seq[c][i] = sn1[c];
        end
        n_checks++;
        if (seq[0] !== 16'h5555) $display("FAIL decor_ch0 got %h want 5555", seq[0]);
        else n_pass++;
        n_checks++;
        if (seq[1] !== 16'hAAAA) $display("FAIL decor_ch1 got %h want aaaa", seq[1]);
        else n_pass++;
        n_checks++;
        if (seq[2] !== 16'h5555) $display("FAIL decor_ch2 got %h want 5555", seq[2]);
        else n_pass++;
        n_checks++;
        if (seq[3] !== 16'hAAAA) $display("FAIL decor_ch3 got %h want aaaa", seq[3]);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ($countones(seq[c]) != 8)
                $display("FAIL decor_count ch%0d got %0d want 8", c, $countones(seq[c]));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (done1 !== 1'b1) $display("FAIL decor_done got %b want 1", done1);
        else n_pass++;
        tick();
    endtask

    task automatic test_latch;
        x0 = {4{4'd11}};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            for (int c = 0; c < 4; c++) seq[c][i] = sn0[c];
            x0 = (i < 3) ? 16'h0000 : 16'h7F3C;
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (seq[c] !== 16'h5DDD)
                $display("FAIL latch_ch%0d got %h want 5ddd", c, seq[c]);
            else n_pass++;
        end
        tick();
        tick();
    endtask

    task automatic test_stop;
        x0 = {4{4'd15}};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        n_checks++;
        if ({valid0, busy0, done0, sn0} !== 7'd0)
            $display("FAIL stop_outputs got %b want 0", {valid0, busy0, done0, sn0});
        else n_pass++;
        vcnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done0 !== 1'b0 || valid0 !== 1'b0) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL stop_no_done got %0d active cycles want 0", vcnt);
        else n_pass++;
        x0 = {4{4'd8}};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            seq[0][i] = sn0[0];
        end
        n_checks++;
        if (seq[0] !== 16'h5555) $display("FAIL restart_ch0 got %h want 5555", seq[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (done0 !== 1'b1) $display("FAIL restart_done got %b want 1", done0);
        else n_pass++;
        tick();
    endtask

    task automatic test_midreset;
        x0 = {4{4'd15}};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({sn0, valid0, busy0, done0} !== 7'd0)
            $display("FAIL midreset_outputs got %b want 0", {sn0, valid0, busy0, done0});
        else n_pass++;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done0 !== 1'b0 || valid0 !== 1'b0) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL midreset_quiet got %0d active cycles want 0", vcnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        x0 = {4'd15, 4'd8, 4'd0, 4'd11};
        start0 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) tick();
        tick();
        n_checks++;
        if ({done0, valid0} !== 2'b10)
            $display("FAIL b2b_done_cycle got %b want 10", {done0, valid0});
        else n_pass++;
        tick();
        n_checks++;
        if ({done0, valid0} !== 2'b00)
            $display("FAIL b2b_idle_cycle got %b want 00", {done0, valid0});
        else n_pass++;
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            for (int c = 0; c < 4; c++) seq[c][i] = sn0[c];
            if (valid0 === 1'b1) vcnt++;
        end
        start0 = 1'b0;
        n_checks++;
        if (vcnt != 16) $display("FAIL b2b_valid_len got %0d want 16", vcnt);
        else n_pass++;
        n_checks++;
        if ({seq[3], seq[2], seq[1], seq[0]} !== 64'h7FFF_5555_0000_5DDD)
            $display("FAIL b2b_streams got %h want 7fff555500005ddd",
                     {seq[3], seq[2], seq[1], seq[0]});
        else n_pass++;
        n_checks++;
        if ($countones(seq[0]) != 11)
            $display("FAIL b2b_count_ch0 got %0d want 11", $countones(seq[0]));
        else n_pass++;
        tick();
        n_checks++;
        if (done0 !== 1'b1) $display("FAIL b2b_second_done got %b want 1", done0);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        x0       = '0;
        x1       = '0;
        start0   = 1'b0;
        start1   = 1'b0;
        stop0    = 1'b0;
        stop1    = 1'b0;
        test_reset();
        test_correlated();
        test_decor();
        test_latch();
        test_stop();
        test_midreset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
